// File: rtl/cpu_clock_controller.sv
// Purpose : run-control tick generator for the CPU clock domain (HALTED / RUN / STEP-N).
// Latency : first tick falls in the div_reg-th cycle after the accepting edge; tick period = div_reg.
// Backpres: cmd_ready is low for the whole of a STEP burst; commands stall until it completes.
//
// Ports:
//   clk_in, reset_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (accept on cmd_valid && cmd_ready)
//   cmd_op, cmd_arg            00 HALT, 01 RUN, 10 STEP (count in arg[STEP_W-1:0]), 11 SET_DIV
//   tick_out                   one-cycle CPU clock enable
//   running                    high in RUN or STEP
//   step_done                  one-cycle pulse in the cycle after the final STEP tick
//   div_cur                    active divisor
// Optional macro CLK_CTRL_TICK_COUNT_EN adds tick_count[31:0] (ticks since reset, wraps);
// with it, SET_DIV 28'hFFFFFFF clears tick_count instead of loading a divisor.
module cpu_clock_controller #(
    parameter logic [27:0] DIVISOR = 28'd50,
    parameter int          STEP_W  = 16
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [27:0] cmd_arg,
    output logic        tick_out,
    output logic        running,
    output logic        step_done,
    output logic [27:0] div_cur
`ifdef CLK_CTRL_TICK_COUNT_EN
    ,
    output logic [31:0] tick_count
`endif
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [1:0]        OP_HALT    = 2'b00;
    localparam logic [1:0]        OP_RUN     = 2'b01;
    localparam logic [1:0]        OP_STEP    = 2'b10;
    localparam logic [1:0]        OP_SET_DIV = 2'b11;
    // A zero divisor would never tick; it is treated as divide-by-one.
    localparam logic [27:0]       DIV_INIT   = (DIVISOR == 28'd0) ? 28'd1 : DIVISOR;
    localparam logic [STEP_W-1:0] ONE_STEP   = STEP_W'(1);

    state_t            state;
    logic [27:0]       counter;
    logic [27:0]       div_reg;
    logic [STEP_W-1:0] steps_left;

    logic              accept;
    logic              tick;
    logic [27:0]       cnt_next;
    logic [27:0]       arg_div;
    logic [STEP_W-1:0] step_arg;
    logic              div_clear;

    assign accept   = cmd_valid && cmd_ready;
    // div_reg >= 1 always holds, so div_reg - 1 cannot underflow.
    assign tick     = (state != ST_HALTED) && (counter == (div_reg - 28'd1));
    assign cnt_next = tick ? 28'd0 : (counter + 28'd1);
    assign arg_div  = (cmd_arg == 28'd0) ? 28'd1 : cmd_arg;
    assign step_arg = cmd_arg[STEP_W-1:0];

`ifdef CLK_CTRL_TICK_COUNT_EN
    // All-ones SET_DIV is reserved as the tick_count clear command.
    assign div_clear = (cmd_arg == 28'hFFFFFFF);
`else
    assign div_clear = 1'b0;
`endif

    assign tick_out  = tick;
    assign running   = (state != ST_HALTED);
    assign cmd_ready = (state != ST_STEP);
    assign div_cur   = div_reg;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HALTED;
            counter    <= 28'd0;
            div_reg    <= DIV_INIT;
            steps_left <= '0;
            step_done  <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                ST_HALTED: begin
                    counter <= 28'd0;
                    if (accept) begin
                        case (cmd_op)
                            OP_RUN:  state <= ST_RUN;
                            OP_STEP: begin
                                // A zero-length step is a silent no-op.
                                if (step_arg != '0) begin
                                    state      <= ST_STEP;
                                    steps_left <= step_arg;
                                end
                            end
                            OP_SET_DIV: begin
                                if (!div_clear) begin
                                    div_reg <= arg_div;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RUN: begin
                    counter <= cnt_next;
                    if (accept) begin
                        case (cmd_op)
                            OP_HALT: begin
                                state   <= ST_HALTED;
                                counter <= 28'd0;
                            end
                            OP_STEP: begin
                                if (step_arg != '0) begin
                                    state      <= ST_STEP;
                                    steps_left <= step_arg;
                                    counter    <= 28'd0;
                                end
                            end
                            OP_SET_DIV: begin
                                // Restarting the count makes the new period start cleanly.
                                if (!div_clear) begin
                                    div_reg <= arg_div;
                                    counter <= 28'd0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_STEP: begin
                    counter <= cnt_next;
                    if (tick) begin
                        if (steps_left == ONE_STEP) begin
                            state      <= ST_HALTED;
                            counter    <= 28'd0;
                            steps_left <= '0;
                            step_done  <= 1'b1;
                        end else begin
                            steps_left <= steps_left - ONE_STEP;
                        end
                    end
                end

                default: begin
                    state   <= ST_HALTED;
                    counter <= 28'd0;
                end
            endcase
        end
    end

`ifdef CLK_CTRL_TICK_COUNT_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_count <= 32'd0;
        end else if (accept && (cmd_op == OP_SET_DIV) && div_clear) begin
            tick_count <= 32'd0;
        end else if (tick) begin
            tick_count <= tick_count + 32'd1;
        end
    end
`endif

endmodule
